mdu_ctrl: RTL

Multiply/divide sequencer and HI/LO owner for the five-stage core, sitting beside EX. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs the multi-cycle shift-subtract divide and, optionally, the shift-add multiply. While an operation is in flight it raises an EX stall request to CTRL. It presents HI/LO to the MFHI/MFLO read path.

---
 rtl/mdu_ctrl_if.sv | 24 ++
 rtl/mdu_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-side bundle between the pipeline and the multiply/divide
// sequencer. The master is the EX/CTRL side, the slave is mdu_ctrl.
interface mdu_ctrl_if;
    logic [5:0]  stall;        // global stall vector, bit 3 = EX held
    logic        op_valid;     // EX holds a valid MDU instruction
    logic [5:0]  op;           // one-hot {mthi, mtlo, multu, mult, divu, div}
    logic [31:0] src_a;        // rs value
    logic [31:0] src_b;        // rt value
    logic        stallreq_ex;  // hold PC..EX
    logic        busy;         // sequencer not idle
    logic        done;         // one-cycle completion pulse
    logic [31:0] hi;           // HI register
    logic [31:0] lo;           // LO register

    modport master (
        output stall, op_valid, op, src_a, src_b,
        input  stallreq_ex, busy, done, hi, lo
    );

    modport slave (
        input  stall, op_valid, op, src_a, src_b,
        output stallreq_ex, busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer and HI/LO owner beside EX.
// Divide is a 32-cycle restoring shift-subtract on operand magnitudes with
// sign correction at the end. Multiply depends on MDU_SEQ_MUL_EN:
//   defined   -> 32-cycle shift-add on magnitudes (same timing as divide)
//   undefined -> single-cycle 32x32 multiply in one MUL_RUN cycle
// While an operation is in flight stallreq_ex holds the front of the pipe.
// DONE is held while stall[3] is set so the instruction still sitting in EX
// does not restart the sequencer.
module mdu_ctrl (
    input  logic       clk,
    input  logic       rst,
    mdu_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIV_RUN = 2'd1,
        S_MUL_RUN = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] rq_q, rq_d;          // divide {rem, quo} / multiply product
    logic [31:0] opa_q, opa_d;        // |src_a|
    logic [31:0] opb_q, opb_d;        // |src_b|
    logic        neg_res_q, neg_res_d; // quotient/product needs negation
    logic        neg_rem_q, neg_rem_d; // remainder takes dividend sign
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Decode of the incoming instruction
    logic        op_onehot;
    logic        op_legal;
    logic        is_div, is_mul, is_signed;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic        start_seq;

    // Only bit 3 of the stall vector matters to this block
    logic        stall_unused;
    assign stall_unused = ^{bus.stall[5:4], bus.stall[2:0]};

    assign op_onehot = (bus.op != 6'd0) && ((bus.op & (bus.op - 6'd1)) == 6'd0);
    assign op_legal  = bus.op_valid && op_onehot;
    assign is_div    = bus.op[0] | bus.op[1];
    assign is_mul    = bus.op[2] | bus.op[3];
    assign is_signed = bus.op[0] | bus.op[2];
    assign a_neg     = is_signed & bus.src_a[31];
    assign b_neg     = is_signed & bus.src_b[31];
    assign mag_a     = a_neg ? (32'd0 - bus.src_a) : bus.src_a;
    assign mag_b     = b_neg ? (32'd0 - bus.src_b) : bus.src_b;
    assign start_seq = (state_q == S_IDLE) && op_legal && (is_div || is_mul);

    // One restoring-division step: shift {rem,quo} left, trial-subtract divisor
    logic [32:0] div_upper;
    logic        div_ge;
    logic [32:0] div_diff;
    logic [63:0] div_step;
    assign div_upper = {rq_q[63:32], rq_q[31]};
    assign div_ge    = (div_upper >= {1'b0, opb_q});
    assign div_diff  = div_upper - {1'b0, opb_q};
    assign div_step  = div_ge ? {div_diff[31:0], rq_q[30:0], 1'b1}
                              : {div_upper[31:0], rq_q[30:0], 1'b0};

    // Multiply datapath: either one shift-add step or the full product
    logic [63:0] mul_res;
`ifdef MDU_SEQ_MUL_EN
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, rq_q[63:32]} + (rq_q[0] ? {1'b0, opa_q} : 33'd0);
    assign mul_res = {mul_sum, rq_q[31:1]};
`else
    assign mul_res = {32'd0, opa_q} * {32'd0, opb_q};
`endif

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            rq_q      <= 64'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rq_q      <= rq_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // Next-state, datapath updates and HI/LO writes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rq_d      = rq_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start_seq) begin
                    opa_d     = mag_a;
                    opb_d     = mag_b;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = 5'd0;
                    if (is_div) begin
                        rq_d    = {32'd0, mag_a};
                        div0_d  = (bus.src_b == 32'd0);
                        state_d = S_DIV_RUN;
                    end else begin
                        rq_d    = {32'd0, mag_b};
                        div0_d  = 1'b0;
                        state_d = S_MUL_RUN;
                    end
                end else if (op_legal && !bus.stall[3]) begin
                    // MTHI/MTLO commit only when the instruction advances
                    if (bus.op[5]) hi_d = bus.src_a;
                    if (bus.op[4]) lo_d = bus.src_a;
                end
            end

            S_DIV_RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (div0_q) begin
                    // Divide by zero: HI gets the original dividend back
                    hi_d    = neg_rem_q ? (32'd0 - opa_q) : opa_q;
                    lo_d    = 32'hFFFF_FFFF;
                    state_d = S_DONE;
                end else begin
                    rq_d = div_step;
                    if (cnt_q == 5'd31) begin
                        hi_d    = neg_rem_q ? (32'd0 - div_step[63:32]) : div_step[63:32];
                        lo_d    = neg_res_q ? (32'd0 - div_step[31:0]) : div_step[31:0];
                        state_d = S_DONE;
                    end
                end
            end

            S_MUL_RUN: begin
`ifdef MDU_SEQ_MUL_EN
                cnt_d = cnt_q + 5'd1;
                rq_d  = mul_res;
                if (cnt_q == 5'd31) begin
                    {hi_d, lo_d} = neg_res_q ? (64'd0 - mul_res) : mul_res;
                    state_d      = S_DONE;
                end
`else
                {hi_d, lo_d} = neg_res_q ? (64'd0 - mul_res) : mul_res;
                state_d      = S_DONE;
`endif
            end

            S_DONE: begin
                // Same instruction still in EX while held; wait for it to leave
                if (!bus.stall[3]) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Completion pulses only on the transition into DONE
    always_comb begin
        done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    assign bus.stallreq_ex = start_seq || (state_q == S_DIV_RUN) || (state_q == S_MUL_RUN);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule
